// File: rtl/stack_mem_unit.sv
// Memory-stage stack and data-memory responder. It owns the stack pointer and the data array,
// splits PC pushes into two 16-bit halves and rejoins them on pop. Results are registered, so they appear 1 cycle after the request.
module stack_mem_unit #(
    parameter int ADDR_W  = 12,
    parameter int SP_INIT = 2**ADDR_W - 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic              mem_push,
    input  logic              mem_pop,
    input  logic [1:0]        mem_addsel,
    input  logic [1:0]        mem_src_select,
    input  logic [15:0]       addr_operand,
    input  logic [15:0]       reg_data,
    input  logic [31:0]       pc_in,
    input  logic [2:0]        flags_in,
    output logic [15:0]       rd_data,
    output logic              rd_valid,
    output logic [31:0]       pc_out,
    output logic              pc_valid,
    output logic [2:0]        flags_out,
    output logic              flags_valid,
    output logic [ADDR_W-1:0] sp,
    output logic              stack_overflow,
    output logic              stack_underflow,
    output logic              protocol_err
);

    localparam int              DEPTH      = 2**ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_FULL = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] DEPTH_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] SP_ONE   = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] SP_RST   = ADDR_W'(SP_INIT);

    localparam logic [0:0] PC_EMPTY = 1'b0;
    localparam logic [0:0] PC_HALF  = 1'b1;

    localparam logic [1:0] SRC_FLAGS = 2'b00;
    localparam logic [1:0] SRC_PCH   = 2'b01;
    localparam logic [1:0] SRC_PCL   = 2'b10;
    localparam logic [1:0] SRC_REG   = 2'b11;

    logic [15:0] mem_q [DEPTH];

    logic [ADDR_W-1:0] sp_q, sp_d;
    logic [ADDR_W:0]   depth_q, depth_d;
    logic [0:0]        pc_state_q, pc_state_d;
    logic [15:0]       pc_lo_q, pc_lo_d;
    logic [15:0]       rd_data_q, rd_data_d;
    logic [31:0]       pc_out_q, pc_out_d;
    logic [2:0]        flags_q, flags_d;
    logic              rd_vld_q, rd_vld_d;
    logic              pc_vld_q, pc_vld_d;
    logic              flags_vld_q, flags_vld_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;
    logic              perr_q, perr_d;

    logic              illegal, is_push, is_pop, is_wr, is_rd;
    logic              full, empty, mem_we;
    logic [ADDR_W-1:0] plain_addr, pop_addr, waddr;
    logic [15:0]       push_word, wdata, rd_word;
    logic              unused_addr_bits;

    assign unused_addr_bits = ^addr_operand[15:ADDR_W];

    // Stack ops must address via SP; a read/write with no address source is a protocol error.
    assign illegal = (mem_push & mem_pop)
                   | (mem_push & ~mem_write)
                   | (mem_pop & ~mem_read)
                   | ((mem_read | mem_write) & (mem_addsel == 2'b00))
                   | ((mem_push | mem_pop) & (mem_addsel != 2'b10));

    assign is_push = ~illegal & mem_push;
    assign is_pop  = ~illegal & mem_pop;
    assign is_wr   = ~illegal & ~mem_push & ~mem_pop & mem_write;
    assign is_rd   = ~illegal & ~mem_push & ~mem_pop & ~mem_write & mem_read;

    assign full       = (depth_q == DEPTH_FULL);
    assign empty      = (depth_q == '0);
    assign plain_addr = (mem_addsel == 2'b10) ? sp_q : addr_operand[ADDR_W-1:0];
    assign pop_addr   = sp_q + SP_ONE;

    always_comb begin
        push_word = reg_data;
        case (mem_src_select)
            SRC_FLAGS: push_word = {13'b0, flags_in};
            SRC_PCH:   push_word = pc_in[31:16];
            SRC_PCL:   push_word = pc_in[15:0];
            default:   push_word = reg_data;
        endcase
    end

    assign mem_we  = (is_push & ~full) | is_wr;
    assign waddr   = is_push ? sp_q : plain_addr;
    assign wdata   = is_push ? push_word : reg_data;
    assign rd_word = mem_q[is_pop ? pop_addr : plain_addr];

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[waddr] <= wdata;
        end
    end

    always_comb begin
        sp_d        = sp_q;
        depth_d     = depth_q;
        pc_state_d  = pc_state_q;
        pc_lo_d     = pc_lo_q;
        rd_data_d   = rd_data_q;
        pc_out_d    = pc_out_q;
        flags_d     = flags_q;
        rd_vld_d    = 1'b0;
        pc_vld_d    = 1'b0;
        flags_vld_d = 1'b0;
        ovf_d       = 1'b0;
        unf_d       = 1'b0;
        perr_d      = illegal;

        if (is_push) begin
            if (full) begin
                ovf_d = 1'b1;
            end else begin
                sp_d    = sp_q - SP_ONE;
                depth_d = depth_q + DEPTH_ONE;
            end
        end else if (is_pop) begin
            if (empty) begin
                unf_d = 1'b1;
            end else begin
                sp_d    = pop_addr;
                depth_d = depth_q - DEPTH_ONE;
                case (mem_src_select)
                    SRC_REG: begin
                        rd_data_d = rd_word;
                        rd_vld_d  = 1'b1;
                    end
                    SRC_FLAGS: begin
                        flags_d     = rd_word[2:0];
                        flags_vld_d = 1'b1;
                    end
                    SRC_PCL: begin
                        // A second low half replaces the first but flags the out-of-order pop.
                        pc_lo_d    = rd_word;
                        pc_state_d = PC_HALF;
                        perr_d     = (pc_state_q == PC_HALF);
                    end
                    default: begin
                        if (pc_state_q == PC_HALF) begin
                            pc_out_d   = {rd_word, pc_lo_q};
                            pc_vld_d   = 1'b1;
                            pc_state_d = PC_EMPTY;
                        end else begin
                            perr_d = 1'b1;
                        end
                    end
                endcase
            end
        end else if (is_rd) begin
            rd_data_d = rd_word;
            rd_vld_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sp_q        <= SP_RST;
            depth_q     <= '0;
            pc_state_q  <= PC_EMPTY;
            pc_lo_q     <= '0;
            rd_data_q   <= '0;
            pc_out_q    <= '0;
            flags_q     <= '0;
            rd_vld_q    <= 1'b0;
            pc_vld_q    <= 1'b0;
            flags_vld_q <= 1'b0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
            perr_q      <= 1'b0;
        end else begin
            sp_q        <= sp_d;
            depth_q     <= depth_d;
            pc_state_q  <= pc_state_d;
            pc_lo_q     <= pc_lo_d;
            rd_data_q   <= rd_data_d;
            pc_out_q    <= pc_out_d;
            flags_q     <= flags_d;
            rd_vld_q    <= rd_vld_d;
            pc_vld_q    <= pc_vld_d;
            flags_vld_q <= flags_vld_d;
            ovf_q       <= ovf_d;
            unf_q       <= unf_d;
            perr_q      <= perr_d;
        end
    end

    assign sp              = sp_q;
    assign rd_data         = rd_data_q;
    assign rd_valid        = rd_vld_q;
    assign pc_out          = pc_out_q;
    assign pc_valid        = pc_vld_q;
    assign flags_out       = flags_q;
    assign flags_valid     = flags_vld_q;
    assign stack_overflow  = ovf_q;
    assign stack_underflow = unf_q;
    assign protocol_err    = perr_q;

endmodule

// File: tb/tb_stack_mem_unit.sv
// Bench for stack_mem_unit: a 12-bit instance for the functional paths and a 3-bit instance for the full/empty edges.
module tb_stack_mem_unit;

    localparam int K_NONE = 0, K_RD = 1, K_PC = 2, K_FL = 3, K_OVF = 4, K_UNF = 5, K_PERR = 6, K_MULTI = 7;

    typedef struct {
        int          cyc;
        int          dut;
        int          kind;
        logic [31:0] data;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [15:0] addr_i = '0, reg_i = '0;
    logic [31:0] pc_i = '0;
    logic [2:0]  fl_i = '0;
    logic [3:0]  ctl_a = '0, ctl_b = '0;
    logic [1:0]  as_a = '0, as_b = '0, src_a = '0, src_b = '0;

    logic [15:0] a_rd, b_rd;
    logic [31:0] a_pc, b_pc;
    logic [2:0]  a_fl, b_fl;
    logic [11:0] a_sp;
    logic [2:0]  b_sp;
    logic a_rdv, a_pcv, a_flv, a_ovf, a_unf, a_perr;
    logic b_rdv, b_pcv, b_flv, b_ovf, b_unf, b_perr;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    ev_t  exp_q[$];
    ev_t  mon_e;
    int   k0, k1, mk;
    logic [31:0] v0, v1, mv;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    stack_mem_unit #(.ADDR_W(12)) dut_a (
        .clk(clk), .reset(rst),
        .mem_read(ctl_a[3]), .mem_write(ctl_a[2]), .mem_push(ctl_a[1]), .mem_pop(ctl_a[0]),
        .mem_addsel(as_a), .mem_src_select(src_a),
        .addr_operand(addr_i), .reg_data(reg_i), .pc_in(pc_i), .flags_in(fl_i),
        .rd_data(a_rd), .rd_valid(a_rdv), .pc_out(a_pc), .pc_valid(a_pcv),
        .flags_out(a_fl), .flags_valid(a_flv), .sp(a_sp),
        .stack_overflow(a_ovf), .stack_underflow(a_unf), .protocol_err(a_perr)
    );

    stack_mem_unit #(.ADDR_W(3)) dut_b (
        .clk(clk), .reset(rst),
        .mem_read(ctl_b[3]), .mem_write(ctl_b[2]), .mem_push(ctl_b[1]), .mem_pop(ctl_b[0]),
        .mem_addsel(as_b), .mem_src_select(src_b),
        .addr_operand(addr_i), .reg_data(reg_i), .pc_in(pc_i), .flags_in(fl_i),
        .rd_data(b_rd), .rd_valid(b_rdv), .pc_out(b_pc), .pc_valid(b_pcv),
        .flags_out(b_fl), .flags_valid(b_flv), .sp(b_sp),
        .stack_overflow(b_ovf), .stack_underflow(b_unf), .protocol_err(b_perr)
    );

    function automatic void observe(input logic rdv, pcv, flv, ovf, unf, perr,
                                    input logic [15:0] rd, input logic [31:0] pc, input logic [2:0] fl,
                                    output int k, output logic [31:0] v);
        int n = 0;
        k = K_NONE;
        v = '0;
        if (rdv)  begin n++; k = K_RD;   v = {16'b0, rd}; end
        if (pcv)  begin n++; k = K_PC;   v = pc;          end
        if (flv)  begin n++; k = K_FL;   v = {29'b0, fl}; end
        if (ovf)  begin n++; k = K_OVF;  v = '0;          end
        if (unf)  begin n++; k = K_UNF;  v = '0;          end
        if (perr) begin n++; k = K_PERR; v = '0;          end
        if (n > 1) k = K_MULTI;
    endfunction

    // Scoreboard monitor: each expected event carries the cycle it must appear in.
    always @(negedge clk) begin
        if (!rst) begin
            observe(a_rdv, a_pcv, a_flv, a_ovf, a_unf, a_perr, a_rd, a_pc, a_fl, k0, v0);
            observe(b_rdv, b_pcv, b_flv, b_ovf, b_unf, b_perr, b_rd, b_pc, b_fl, k1, v1);
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                mon_e = exp_q.pop_front();
                checks++; errors++;
                $display("FAIL missing_event dut%0d kind %0d at cycle %0d: got nothing, required data %h",
                         mon_e.dut, mon_e.kind, mon_e.cyc, mon_e.data);
            end
            if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                mon_e = exp_q.pop_front();
                mk = (mon_e.dut == 0) ? k0 : k1;
                mv = (mon_e.dut == 0) ? v0 : v1;
                checks++;
                if (mk != mon_e.kind || mv != mon_e.data) begin
                    errors++;
                    $display("FAIL event dut%0d cycle %0d: got kind %0d data %h, required kind %0d data %h",
                             mon_e.dut, cyc, mk, mv, mon_e.kind, mon_e.data);
                end
                if (((mon_e.dut == 0) ? k1 : k0) != K_NONE) begin
                    checks++; errors++;
                    $display("FAIL idle_dut_event cycle %0d: got a pulse on the idle instance, required none", cyc);
                end
            end else if (k0 != K_NONE || k1 != K_NONE) begin
                checks++; errors++;
                $display("FAIL unexpected_event cycle %0d: got kinds %0d/%0d, required none", cyc, k0, k1);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // Drives one request for a cycle; the expected response (if any) is due one cycle later.
    task automatic op(input int d, input logic [3:0] ctl, input logic [1:0] as, input logic [1:0] src,
                      input logic [15:0] ad, input logic [15:0] rg, input int ek, input logic [31:0] ed);
        ev_t e;
        if (ek != K_NONE) begin
            e.cyc = cyc + 1; e.dut = d; e.kind = ek; e.data = ed;
            exp_q.push_back(e);
        end
        addr_i = ad;
        reg_i  = rg;
        if (d == 0) begin ctl_a = ctl; as_a = as; src_a = src; end
        else        begin ctl_b = ctl; as_b = as; src_b = src; end
        @(negedge clk);
        ctl_a = '0; as_a = '0; src_a = '0;
        ctl_b = '0; as_b = '0; src_b = '0;
    endtask

    task automatic push_op(input int d, input logic [1:0] src, input logic [15:0] rg, input int ek);
        op(d, 4'b0110, 2'b10, src, 16'h0, rg, ek, 32'h0);
    endtask

    task automatic pop_op(input int d, input logic [1:0] src, input int ek, input logic [31:0] ed);
        op(d, 4'b1001, 2'b10, src, 16'h0, 16'h0, ek, ed);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        @(negedge clk);
        chk("reset_sp_a", {20'b0, a_sp}, 32'h0000_0FFF);
        chk("reset_sp_b", {29'b0, b_sp}, 32'h0000_0007);
        chk("reset_outputs_a", {a_rdv, a_pcv, a_flv, a_ovf, a_unf, a_perr, a_pc, a_rd, a_fl},
            {6'b0, 32'h0, 16'h0, 3'b0});
        rst = 1'b0;

        // Register push/pop round trip.
        push_op(0, 2'b11, 16'hBEEF, K_NONE);
        chk("sp_after_push", {20'b0, a_sp}, 32'h0000_0FFE);
        pop_op(0, 2'b11, K_RD, 32'h0000_BEEF);
        chk("sp_after_pop", {20'b0, a_sp}, 32'h0000_0FFF);

        // CALL/RET.
        pc_i = 32'h0001_2345;
        push_op(0, 2'b01, 16'h0, K_NONE);
        push_op(0, 2'b10, 16'h0, K_NONE);
        chk("sp_call", {20'b0, a_sp}, 32'h0000_0FFD);
        pop_op(0, 2'b10, K_NONE, 32'h0);
        pop_op(0, 2'b01, K_PC, 32'h0001_2345);
        chk("sp_ret", {20'b0, a_sp}, 32'h0000_0FFF);

        // Interrupt/RTI.
        pc_i = 32'hDEAD_1234;
        fl_i = 3'b101;
        push_op(0, 2'b01, 16'h0, K_NONE);
        push_op(0, 2'b10, 16'h0, K_NONE);
        push_op(0, 2'b00, 16'h0, K_NONE);
        pc_i = 32'h0;
        fl_i = 3'b000;
        pop_op(0, 2'b00, K_FL, 32'h0000_0005);
        pop_op(0, 2'b10, K_NONE, 32'h0);
        pop_op(0, 2'b01, K_PC, 32'hDEAD_1234);

        // High half popped with no low half latched, then push and pop together.
        push_op(0, 2'b11, 16'h1111, K_NONE);
        pop_op(0, 2'b01, K_PERR, 32'h0);
        op(0, 4'b1111, 2'b10, 2'b11, 16'h0, 16'h2222, K_PERR, 32'h0);
        chk("sp_illegal", {20'b0, a_sp}, 32'h0000_0FFF);

        // Plain LDD/STD, upper address bits ignored, missing address source.
        op(0, 4'b0100, 2'b01, 2'b00, 16'h0010, 16'h1234, K_NONE, 32'h0);
        op(0, 4'b0100, 2'b11, 2'b00, 16'h0011, 16'hABCD, K_NONE, 32'h0);
        op(0, 4'b1000, 2'b01, 2'b00, 16'h0010, 16'h0, K_RD, 32'h0000_1234);
        op(0, 4'b1000, 2'b11, 2'b00, 16'hF011, 16'h0, K_RD, 32'h0000_ABCD);
        op(0, 4'b1000, 2'b00, 2'b00, 16'h0010, 16'h0, K_PERR, 32'h0);
        pop_op(0, 2'b11, K_UNF, 32'h0);
        chk("sp_ldd_std", {20'b0, a_sp}, 32'h0000_0FFF);

        // Reset while a PC low half is latched.
        pc_i = 32'h0007_8888;
        push_op(0, 2'b01, 16'h0, K_NONE);
        push_op(0, 2'b10, 16'h0, K_NONE);
        pop_op(0, 2'b10, K_NONE, 32'h0);
        chk("sp_half", {20'b0, a_sp}, 32'h0000_0FFE);
        rst = 1'b1;
        #1;
        chk("sp_async_reset", {20'b0, a_sp}, 32'h0000_0FFF);
        @(negedge clk);
        rst = 1'b0;
        push_op(0, 2'b01, 16'h0, K_NONE);
        pop_op(0, 2'b01, K_PERR, 32'h0);

        // Eight-deep instance: fill, overflow, drain, underflow.
        for (int i = 0; i < 8; i++) push_op(1, 2'b11, 16'h0100 + 16'(i), K_NONE);
        chk("sp_full", {29'b0, b_sp}, 32'h0000_0007);
        push_op(1, 2'b11, 16'h01FF, K_OVF);
        chk("sp_overflow", {29'b0, b_sp}, 32'h0000_0007);
        for (int i = 7; i >= 0; i--) pop_op(1, 2'b11, K_RD, 32'h0000_0100 + 32'(i));
        pop_op(1, 2'b11, K_UNF, 32'h0);
        chk("sp_underflow", {29'b0, b_sp}, 32'h0000_0007);

        repeat (3) @(negedge clk);
        chk("pending_events", 32'(exp_q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
